systolic_seq: RTL and testbench
===============================

// Module: systolic_seq
// PURPOSE
//  Sequencer for a DIM x DIM output-stationary systolic MAC array. One job computes C = A*B with inner length k_len.
//  Accepts a job on a start pulse, clears the PE accumulators and drives skewed per-row/column feed enables.
//  Waits for the wavefront to drain through the array, then unloads result rows to a sink over a valid/ready handshake.
//  Sits between the operand buffers / host control and the array plus result buffer.
// PARAMETERS
//  DIM  8  array rows = columns; >= 2
//  KW   8  width of k_len; max inner length 2**KW-1
// PORTS
//  clk          in   1             clock; all logic on posedge
//  rst          in   1             asynchronous, active-high reset
//  start        in   1             job request; sampled only in IDLE
//  k_len        in   KW            inner dimension; captured on accepted start
//  op_valid     in   1             operand buffers have data for this cycle; low = stall
//  abort        in   1             synchronous cancel; any state -> IDLE next cycle
//  busy         out  1             high from the cycle after accept until done
//  acc_clr      out  1             one-cycle pulse: clear all PE accumulators
//  feed_en      out  DIM           feed_en[i]: row i of A and column i of B shift this cycle
//  res_valid    out  1             result row on array output is valid
//  res_row      out  $clog2(DIM)   index of the row being unloaded
//  res_ready    in   1             sink accepts row when res_valid & res_ready
//  done         out  1             one-cycle pulse, job complete
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, k_q=0; busy, acc_clr, feed_en, res_valid, res_row, done = 0.
//  States: IDLE -> CLR -> FEED -> DRAIN -> FIN -> IDLE.
//  - IDLE: start=1 & k_len!=0 -> latch k_q=k_len, go to CLR. start with k_len==0 is ignored and stays in IDLE.
//  - CLR: acc_clr=1 for exactly one cycle; cnt<=0; go to FEED.
//  - FEED: cnt advances by 1 only when op_valid=1; it holds otherwise.
//      feed_en[i] = op_valid & (cnt >= i) & (cnt < i + k_q), combinational from the registered cnt/state.
//      Leave when cnt == k_q + 2*(DIM-1) - 1 with op_valid=1. That is the last PE (DIM-1,DIM-1) MAC cycle.
//      Phase length = k_q + 2*DIM - 2 unstalled cycles.
//  - DRAIN: res_valid=1; res_row starts at 0.
//      Each res_valid & res_ready increments res_row.
//      Handshake on row DIM-1 -> FIN. res_valid stays high while res_ready=0 (no drop).
//  - FIN: done=1 for one cycle; -> IDLE.
//  busy=1 in CLR, FEED and DRAIN; busy=0 in FIN and IDLE.
//  Latency from accepted start to done, no stalls and res_ready=1: 1 + (k_q + 2*DIM - 2) + DIM + 1 cycles.
//  cnt width = KW+$clog2(2*DIM)+1 (no overflow at k_q=2**KW-1). The i+k_q compare is done at cnt width.
//  start while busy is ignored; k_len changes after accept have no effect.
//  abort has priority over every transition: next state IDLE, all outputs 0 next cycle, no done pulse.
//  abort and start in the same cycle in IDLE: abort wins, no accept.
//  op_valid low in any state other than FEED has no effect. res_ready outside DRAIN is ignored.
//  rst asserted mid-job: immediate return to reset values; no done pulse.
// STRUCTURE
//  systolic_pkg: state enum (IDLE, CLR, FEED, DRAIN, FIN) and a function feed_len(k,dim) = k+2*dim-2.
//  Sub-module systolic_skew_gen (DIM, CW params): maps cnt, k_q, active -> feed_en[DIM-1:0]. Purely combinational.
//  Top holds the FSM, cnt, k_q, res_row registers.
// TESTING  (DIM=4, KW=8)
//  1. rst high mid-FEED -> next posedge-independent: busy=0, feed_en=0, state IDLE; no done.
//  2. start, k_len=3, op_valid=1, res_ready=1:
//       acc_clr one cycle after accept; FEED lasts 9 cycles.
//       feed_en[0] high FEED cycles 0-2; feed_en[3] high cycles 3-5.
//       res_row 0..3 over 4 cycles; done 15 cycles after accept.
//  3. Same job with op_valid low for 2 cycles at FEED cycle 4:
//       feed_en=0 and cnt frozen for those 2 cycles; done 17 cycles after accept.
//  4. res_ready low for 3 cycles with res_row=1 -> res_valid held, res_row stays 1; done delayed 3 cycles.
//  5. start with k_len=0 -> stays IDLE, busy=0.
//     start during FEED with k_len=7 -> ignored, job keeps k_q=3.
//  6. abort during DRAIN at res_row=2 -> IDLE next cycle, res_valid=0, no done.
//     A new start with k_len=1 then runs normally: FEED 7 cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, FIN} state_t;

    // Number of unstalled FEED cycles until the last PE finishes its final MAC.
    function automatic int unsigned feed_len(input int unsigned k, input int unsigned dim);
        return k + 2 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Skewed feed enables: row/column i is live for k_q steps starting at step i.
module systolic_skew_gen #(
    parameter int DIM = 8,
    parameter int CW  = 13
) (
    input  logic [CW-1:0]  cnt,
    input  logic [CW-1:0]  k_q,
    input  logic           active,
    output logic [DIM-1:0] feed_en
);

    always_comb begin
        feed_en = '0;
        for (int i = 0; i < DIM; i++) begin
            feed_en[i] = active && (cnt >= CW'(i)) && (cnt < CW'(i) + k_q);
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for a DIM x DIM output-stationary systolic MAC array.
//  state | meaning
//  IDLE  | waiting for start with nonzero k_len
//  CLR   | one-cycle accumulator clear
//  FEED  | skewed operand feed, cnt advances on op_valid
//  DRAIN | unload result rows over valid/ready
//  FIN   | one-cycle done pulse
module systolic_seq #(
    parameter int DIM = 8,
    parameter int KW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   op_valid,
    input  logic                   abort,
    output logic                   busy,
    output logic                   acc_clr,
    output logic [DIM-1:0]         feed_en,
    output logic                   res_valid,
    output logic [$clog2(DIM)-1:0] res_row,
    input  logic                   res_ready,
    output logic                   done
);
    import systolic_pkg::*;

    localparam int CW = KW + $clog2(2 * DIM) + 1;
    localparam int RW = $clog2(DIM);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   last_cnt;

    assign last_cnt = CW'(feed_len(32'(k_q), DIM) - 1);

    systolic_skew_gen #(
        .DIM (DIM),
        .CW  (CW)
    ) u_skew (
        .cnt     (cnt),
        .k_q     (CW'(k_q)),
        .active  ((state == FEED) && op_valid),
        .feed_en (feed_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            k_q       <= '0;
            busy      <= 1'b0;
            acc_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_row   <= '0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            acc_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_row   <= '0;
            done      <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        k_q     <= k_len;
                        state   <= CLR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                CLR: begin
                    cnt   <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (op_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == last_cnt) begin
                            state     <= DRAIN;
                            res_valid <= 1'b1;
                            res_row   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (res_row == RW'(DIM - 1)) begin
                            state     <= FIN;
                            res_valid <= 1'b0;
                            res_row   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            res_row <= res_row + RW'(1);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq at DIM=4, KW=8.
module tb_systolic_seq;
    localparam int DIM = 4;
    localparam int KW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [KW-1:0]  k_len;
    logic           op_valid;
    logic           abort;
    logic           busy;
    logic           acc_clr;
    logic [DIM-1:0] feed_en;
    logic           res_valid;
    logic [1:0]     res_row;
    logic           res_ready;
    logic           done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int row_q[$];
    int done_q[$];

    systolic_seq #(.DIM(DIM), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .op_valid  (op_valid),
        .abort     (abort),
        .busy      (busy),
        .acc_clr   (acc_clr),
        .feed_en   (feed_en),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_ready (res_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; handshakes and done pulses are scored against the queues.
    task automatic step();
        logic hs;
        int   row;
        hs  = res_valid && res_ready;
        row = int'(res_row);
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            if (row_q.size() == 0) chk("row_unexpected", hs, 1'b0);
            else chk("res_row_seq", row, row_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", done, 1'b0);
            else chk("done_cycle", cyc, done_q.pop_front());
        end
    endtask

    function automatic logic [DIM-1:0] exp_feed(input int f, input int k, input logic ov);
        logic [DIM-1:0] e;
        for (int i = 0; i < DIM; i++) e[i] = ov && (f >= i) && (f < i + k);
        return e;
    endfunction

    // Full job with optional op_valid stall (at feed step stall_at) and res_ready hold on hold_row.
    task automatic run_job(input int k, input int stall_at, input int stall_n,
                           input int hold_row, input int hold_n);
        int f, stalled, held, n, flen;
        flen = k + 2 * DIM - 2;
        for (int r = 0; r < DIM; r++) row_q.push_back(r);
        done_q.push_back(cyc + 1 + flen + DIM + 1 + stall_n + hold_n);
        start = 1'b1; k_len = KW'(k); op_valid = 1'b1; res_ready = 1'b1;
        step();
        start = 1'b0;
        chk("clr_acc_clr", acc_clr, 1'b1);
        chk("clr_busy", busy, 1'b1);
        chk("clr_feed_en", feed_en, '0);
        step();
        f = 0; stalled = 0; n = 0;
        while (f < flen && n < 200) begin
            op_valid = !(f == stall_at && stalled < stall_n);
            if (!op_valid) stalled++;
            start = (f == 2);
            k_len = (f == 2) ? KW'(7) : KW'(k);
            #1;
            chk("feed_en", feed_en, exp_feed(f, k, op_valid));
            chk("feed_res_valid", res_valid, 1'b0);
            if (op_valid) f++;
            step();
            n++;
        end
        start = 1'b0; op_valid = 1'b1;
        chk("drain_entry_valid", res_valid, 1'b1);
        chk("drain_entry_row", res_row, 2'd0);
        held = 0; n = 0;
        while (!done && n < 40) begin
            if (res_valid && int'(res_row) == hold_row && held < hold_n) begin
                res_ready = 1'b0;
                held++;
                step();
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_row", res_row, 2'(hold_row));
            end else begin
                res_ready = 1'b1;
                step();
            end
            n++;
        end
        chk("done_seen", done, 1'b1);
        chk("fin_busy", busy, 1'b0);
        step();
        chk("post_done_pulse", done, 1'b0);
        chk("post_idle_busy", busy, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; k_len = '0; op_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_acc_clr", acc_clr, 1'b0);
        chk("rst_feed_en", feed_en, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_row", res_row, 2'd0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        step();

        // Reset asserted in the middle of FEED.
        start = 1'b1; k_len = 8'd3; op_valid = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("midfeed_feed_en", feed_en, 4'b0111);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_feed_en", feed_en, '0);
        #2 rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("rstmid_stays_idle", busy, 1'b0);

        // Clean job, stalled job, held-ready job.
        run_job(3, -1, 0, -1, 0);
        run_job(3, 4, 2, -1, 0);
        run_job(3, -1, 0, 1, 3);

        // Zero-length start is ignored; abort beats start in IDLE.
        start = 1'b1; k_len = 8'd0;
        step();
        chk("k0_busy", busy, 1'b0);
        chk("k0_acc_clr", acc_clr, 1'b0);
        k_len = 8'd5; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_acc_clr", acc_clr, 1'b0);
        step();
        chk("abort_start_idle", busy, 1'b0);

        // Abort during DRAIN at row 2: rows 0 and 1 hand off, then no done.
        row_q.push_back(0); row_q.push_back(1);
        start = 1'b1; k_len = 8'd3; op_valid = 1'b1; res_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(res_valid && res_row == 2'd2) && n < 40) begin
            step();
            n++;
        end
        chk("abort_reach_row2", res_row, 2'd2);
        res_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_res_row", res_row, 2'd0);
        for (int i = 0; i < 5; i++) step();
        chk("abort_rows_consumed", row_q.size(), 0);

        run_job(1, -1, 0, -1, 0);

        chk("row_q_empty", row_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
